// File: rtl/mem_block_responder_if.sv
// Memory-side bus between the cache controller (master) and the memory responder (slave).
// Carries the request phase, the write-beat stream and the read-beat stream.
interface mem_block_responder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_wvalid;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;
   logic                  mem_rlast;
   logic                  mem_wready;
   logic                  mem_wack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
      input  mem_ready, mem_rdata, mem_rvalid, mem_rlast, mem_wready, mem_wack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
      output mem_ready, mem_rdata, mem_rvalid, mem_rlast, mem_wready, mem_wack
   );
endinterface

// File: rtl/mem_block_responder.sv
// Block-burst main-memory responder: fixed-latency line fills and write-backs of one
// cache block, one word per beat, over a block-aligned, depth-aliased word address.
module mem_block_responder #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned MEM_DEPTH       = 256,
   parameter int unsigned LATENCY         = 4
) (
   input logic                  clk,
   input logic                  rst,
   mem_block_responder_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
   localparam int unsigned BEAT_W = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [IDX_W-1:0]  ALIGN_MASK = ~IDX_W'(WORDS_PER_BLOCK - 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RBURST,
      S_WBURST
   } state_e;

   // Backing store; deliberately not reset so committed data survives rst.
   logic [DATA_WIDTH-1:0] store [MEM_DEPTH];

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      base_q, base_d;
   logic                  we_q, we_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  ready_q, ready_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rlast_q, rlast_d;
   logic                  wready_q, wready_d;
   logic                  wack_q, wack_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [BEAT_W-1:0]     beat_inc_c;
   logic [IDX_W-1:0]      rd_idx_c;
   logic [IDX_W-1:0]      wr_idx_c;
   logic                  wr_en_c;

   assign beat_inc_c = beat_q + BEAT_W'(1);
   assign wr_idx_c   = base_q + IDX_W'(beat_q);

   // Address bits above the storage index only alias; they carry no meaning here.
   generate
      if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.mem_addr[ADDR_WIDTH-1:IDX_W];
      end
   endgenerate

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         beat_q   <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         wready_q <= 1'b0;
         wack_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         beat_q   <= beat_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         wready_q <= wready_d;
         wack_q   <= wack_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         store[wr_idx_c] <= bus.mem_wdata;
      end
   end

   // Next-state and next-output logic; output registers hold the value for the next cycle.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      beat_d   = beat_q;
      ready_d  = 1'b0;
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
      wready_d = 1'b0;
      wack_d   = 1'b0;
      rdata_d  = rdata_q;
      rd_idx_c = base_q;
      wr_en_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (bus.mem_req) begin
               base_d  = bus.mem_addr[IDX_W-1:0] & ALIGN_MASK;
               we_d    = bus.mem_we;
               cnt_d   = CNT_LOAD;
               ready_d = 1'b0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               beat_d = '0;
               if (we_q) begin
                  wready_d = 1'b1;
                  state_d  = S_WBURST;
               end else begin
                  rd_idx_c = base_q;
                  rdata_d  = store[rd_idx_c];
                  rvalid_d = 1'b1;
                  state_d  = S_RBURST;
               end
            end
         end

         S_RBURST: begin
            beat_d = beat_inc_c;
            if (beat_q == LAST_BEAT) begin
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               rd_idx_c = base_q + IDX_W'(beat_inc_c);
               rdata_d  = store[rd_idx_c];
               rvalid_d = 1'b1;
               rlast_d  = (beat_inc_c == LAST_BEAT);
            end
         end

         S_WBURST: begin
            wready_d = 1'b1;
            if (bus.mem_wvalid) begin
               wr_en_c = 1'b1;
               beat_d  = beat_inc_c;
               if (beat_q == LAST_BEAT) begin
                  wready_d = 1'b0;
                  wack_d   = 1'b1;
                  ready_d  = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end

         default: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.mem_ready  = ready_q;
   assign bus.mem_rdata  = rdata_q;
   assign bus.mem_rvalid = rvalid_q;
   assign bus.mem_rlast  = rlast_q;
   assign bus.mem_wready = wready_q;
   assign bus.mem_wack   = wack_q;
endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: default instance plus a LATENCY=1, two-beat instance.
module tb_mem_block_responder;
   localparam int unsigned LAT = 4;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mem_block_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   mem_block_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

   mem_block_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_BLOCK(4), .MEM_DEPTH(256), .LATENCY(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   mem_block_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_BLOCK(2), .MEM_DEPTH(16), .LATENCY(1)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write one block; vpat bit i is mem_wvalid in the i-th WBURST cycle.
   task automatic do_write(input string tag, input logic [31:0] addr, input int nv,
                           input logic [7:0] vpat, input logic [3:0][31:0] dat);
      int n;
      int commits;
      logic v;
      check_eq({tag, "_rdy"}, 32'(bus.mem_ready), 32'd1);
      bus.mem_req    = 1'b1;
      bus.mem_we     = 1'b1;
      bus.mem_addr   = addr;
      bus.mem_wvalid = 1'b1;
      bus.mem_wdata  = 32'hDEAD_0000;
      tick();
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      check_eq({tag, "_busy"}, 32'(bus.mem_ready), 32'd0);
      n = 0;
      while (!bus.mem_wready && n < 20) begin
         n++;
         tick();
      end
      check_eq({tag, "_lat"}, 32'(n), 32'(LAT));
      commits = 0;
      for (int i = 0; i < nv; i++) begin
         v = vpat[i];
         bus.mem_wvalid = v;
         bus.mem_wdata  = v ? dat[commits] : 32'hEEEE_EEEE;
         check_eq({tag, "_wrdy"}, 32'(bus.mem_wready), 32'd1);
         tick();
         if (v) commits++;
         check_eq({tag, "_wack"}, 32'(bus.mem_wack), 32'((v && commits == 4) ? 1 : 0));
         if (commits == 4) check_eq({tag, "_rdy_end"}, 32'(bus.mem_ready), 32'd1);
      end
      bus.mem_wvalid = 1'b0;
      tick();
      check_eq({tag, "_wack_off"}, 32'(bus.mem_wack), 32'd0);
   endtask

   // Read one block and check the first nchk beats; inj drives ignored inputs meanwhile.
   task automatic do_read(input string tag, input logic [31:0] addr, input int nchk,
                          input bit inj, input logic [3:0][31:0] exp);
      int n;
      check_eq({tag, "_rdy"}, 32'(bus.mem_ready), 32'd1);
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = addr;
      tick();
      check_eq({tag, "_busy"}, 32'(bus.mem_ready), 32'd0);
      bus.mem_req    = inj;
      bus.mem_we     = inj;
      bus.mem_addr   = 32'h0000_0020;
      bus.mem_wvalid = inj;
      bus.mem_wdata  = 32'hFFFF_FFFF;
      n = 0;
      while (!bus.mem_rvalid && n < 20) begin
         n++;
         tick();
      end
      check_eq({tag, "_lat"}, 32'(n), 32'(LAT));
      for (int k = 0; k < 4; k++) begin
         check_eq({tag, "_rvalid"}, 32'(bus.mem_rvalid), 32'd1);
         if (k < nchk) check_eq({tag, "_rdata"}, bus.mem_rdata, exp[k]);
         check_eq({tag, "_rlast"}, 32'(bus.mem_rlast), 32'((k == 3) ? 1 : 0));
         check_eq({tag, "_rdy_burst"}, 32'(bus.mem_ready), 32'd0);
         bus.mem_req = inj & ~k[0];
         tick();
      end
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_wvalid = 1'b0;
      check_eq({tag, "_rvalid_off"}, 32'(bus.mem_rvalid), 32'd0);
      check_eq({tag, "_rdy_end"}, 32'(bus.mem_ready), 32'd1);
   endtask

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_rdy;
      logic [7:0] exp_rv;
      logic [7:0] exp_rl;
      logic [31:0] exp_d2;
      n_cmp = 0;
      n_err = 0;
      bus.mem_req = 1'b0;  bus.mem_we = 1'b0;  bus.mem_addr = '0;
      bus.mem_wdata = '0;  bus.mem_wvalid = 1'b0;
      bus2.mem_req = 1'b0; bus2.mem_we = 1'b0; bus2.mem_addr = '0;
      bus2.mem_wdata = '0; bus2.mem_wvalid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check_eq("rst_ready",  32'(bus.mem_ready),  32'd1);
      check_eq("rst_rvalid", 32'(bus.mem_rvalid), 32'd0);
      check_eq("rst_rlast",  32'(bus.mem_rlast),  32'd0);
      check_eq("rst_wready", 32'(bus.mem_wready), 32'd0);
      check_eq("rst_wack",   32'(bus.mem_wack),   32'd0);
      check_eq("rst_rdata",  bus.mem_rdata,       32'd0);
      check_eq("rst_ready2", 32'(bus2.mem_ready), 32'd1);
      tick();

      do_write("wr10", 32'h10, 4, 8'b0000_1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      do_read("rd10", 32'h10, 4, 1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      do_read("rd113", 32'h113, 4, 1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      do_write("wr20", 32'h20, 7, 8'b0101_1001, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      do_read("rd20", 32'h20, 4, 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      do_read("rdinj", 32'h10, 4, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      do_read("rd20b", 32'h20, 4, 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0});

      // Reset during write beat 2 of a burst to 0x30.
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h30;
      tick();
      bus.mem_req = 1'b0; bus.mem_we = 1'b0;
      for (int i = 0; i < 20 && !bus.mem_wready; i++) tick();
      check_eq("abort_wrdy", 32'(bus.mem_wready), 32'd1);
      bus.mem_wvalid = 1'b1;
      bus.mem_wdata  = 32'hB0;
      tick();
      bus.mem_wdata  = 32'hB1;
      tick();
      bus.mem_wdata  = 32'hB2;
      #2;
      rst = 1'b1;
      #1;
      check_eq("abort_ready",  32'(bus.mem_ready),  32'd1);
      check_eq("abort_wready", 32'(bus.mem_wready), 32'd0);
      check_eq("abort_rvalid", 32'(bus.mem_rvalid), 32'd0);
      check_eq("abort_rlast",  32'(bus.mem_rlast),  32'd0);
      check_eq("abort_wack",   32'(bus.mem_wack),   32'd0);
      check_eq("abort_rdata",  bus.mem_rdata,       32'd0);
      bus.mem_wvalid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      do_read("rd30", 32'h30, 2, 1'b0, {32'h0, 32'h0, 32'hB1, 32'hB0});

      // Short instance: write block 0, then back-to-back reads with mem_req held.
      check_eq("s_rdy", 32'(bus2.mem_ready), 32'd1);
      bus2.mem_req = 1'b1; bus2.mem_we = 1'b1; bus2.mem_addr = 32'h0;
      bus2.mem_wvalid = 1'b1; bus2.mem_wdata = 32'h11;
      tick();
      bus2.mem_req = 1'b0; bus2.mem_we = 1'b0;
      check_eq("s_wait_wrdy", 32'(bus2.mem_wready), 32'd0);
      tick();
      check_eq("s_wrdy", 32'(bus2.mem_wready), 32'd1);
      tick();
      check_eq("s_wack0", 32'(bus2.mem_wack), 32'd0);
      bus2.mem_wdata = 32'h22;
      tick();
      check_eq("s_wack1", 32'(bus2.mem_wack), 32'd1);
      check_eq("s_wrdy_end", 32'(bus2.mem_ready), 32'd1);
      bus2.mem_wvalid = 1'b0;

      exp_rdy = 8'b1000_1000;
      exp_rv  = 8'b0110_0110;
      exp_rl  = 8'b0100_0100;
      bus2.mem_req = 1'b1; bus2.mem_we = 1'b0; bus2.mem_addr = 32'h40;
      tick();
      for (int i = 0; i < 8; i++) begin
         check_eq("s_ready",  32'(bus2.mem_ready),  32'(exp_rdy[i]));
         check_eq("s_rvalid", 32'(bus2.mem_rvalid), 32'(exp_rv[i]));
         check_eq("s_rlast",  32'(bus2.mem_rlast),  32'(exp_rl[i]));
         if (exp_rv[i]) begin
            exp_d2 = exp_rl[i] ? 32'h22 : 32'h11;
            check_eq("s_rdata", bus2.mem_rdata, exp_d2);
         end
         if (i == 7) bus2.mem_req = 1'b0;
         else tick();
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
